// File: rtl/gfau_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gfau_arbiter
// Description : Round-robin arbiter/sequencer sharing one GFAU (GF(p)
//               add/sub/mult/div unit) among N_REQ requesters. Latches the
//               granted requester's operands, pulses the GFAU start, waits
//               for the GFAU done and returns the result with a one-cycle
//               acknowledge.
// Ports       : i_clk/i_rst       clock, asynchronous active-low reset
//               i_req             per-requester request levels
//               i_op_a/i_op_b     packed operands (slice k = requester k)
//               i_op_sel          packed op codes (0 add,1 sub,2 mult,3 div)
//               i_prime           shared field modulus
//               o_gnt/o_ack       one-hot grant / one-cycle result strobe
//               o_result/o_err    result and watchdog-abort flag (with ack)
//               o_busy            FSM not idle
//               o_gf_*            registered GFAU operands, op and start
//               i_gf_result/done  GFAU result and completion pulse
// Options     : GFAU_ARB_TIMEOUT_EN - builds a WAIT-state watchdog that
//               aborts after TIMEOUT_CYCLES cycles without a GFAU done.
// Revision    : 1.0 - initial release
// ============================================================================
module gfau_arbiter #(
  parameter int SIZE           = 32,
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*SIZE-1:0] i_op_a,
  input  logic [N_REQ*SIZE-1:0] i_op_b,
  input  logic [N_REQ*2-1:0]    i_op_sel,
  input  logic [SIZE-1:0]       i_prime,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [N_REQ-1:0]      o_ack,
  output logic [SIZE-1:0]       o_result,
  output logic                  o_err,
  output logic                  o_busy,
  output logic [SIZE-1:0]       o_gf_in_0,
  output logic [SIZE-1:0]       o_gf_in_1,
  output logic [SIZE-1:0]       o_gf_prime,
  output logic [1:0]            o_gf_op_sel,
  output logic                  o_gf_start,
  input  logic [SIZE-1:0]       i_gf_result,
  input  logic                  i_gf_done
);

  localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W-1:0] r_idx;
  logic [c_PTR_W-1:0] w_pick;
  logic               w_found;
  logic [N_REQ-1:0]   r_gnt;
  logic [SIZE-1:0]    r_result;
  logic [SIZE-1:0]    r_gf_in_0;
  logic [SIZE-1:0]    r_gf_in_1;
  logic [SIZE-1:0]    r_gf_prime;
  logic [1:0]         r_gf_op_sel;
  logic               w_timeout;
  logic               w_err;

  // --------------------------------------------------------------------------
  // Round-robin pick: scan offsets from the highest down so the lowest
  // offset from r_ptr that has a request is the one left standing.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [c_PTR_W:0] v_sum;
    v_sum   = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      v_sum = {1'b0, r_ptr} + (c_PTR_W + 1)'(i);
      if (v_sum >= (c_PTR_W + 1)'(N_REQ)) begin
        v_sum = v_sum - (c_PTR_W + 1)'(N_REQ);
      end
      if (i_req[v_sum[c_PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = v_sum[c_PTR_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional watchdog
  // --------------------------------------------------------------------------
`ifdef GFAU_ARB_TIMEOUT_EN
  localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_WD_W-1:0] r_wd_cnt;
  logic              r_err;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_WAIT) begin
        r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
        // A done arriving in the expiry cycle still wins.
        r_err    <= w_timeout && !i_gf_done;
      end else begin
        r_wd_cnt <= '0;
      end
    end
  end

  // Counter is 0 in the first WAIT cycle, so TIMEOUT_CYCLES-1 marks the
  // last WAIT cycle before the abort.
  assign w_timeout = (r_state == S_WAIT) &&
                     (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));
  assign w_err     = r_err;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
  assign w_err            = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    o_gf_start  = 1'b0;
    o_busy      = 1'b1;
    o_ack       = '0;
    o_result    = '0;
    o_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (w_found) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_gf_start  = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_gf_done || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        o_ack       = r_gnt;
        o_result    = r_result;
        o_err       = w_err;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Grant, pointer, operand and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ptr       <= '0;
      r_idx       <= '0;
      r_gnt       <= '0;
      r_result    <= '0;
      r_gf_in_0   <= '0;
      r_gf_in_1   <= '0;
      r_gf_prime  <= '0;
      r_gf_op_sel <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx       <= w_pick;
            r_gnt       <= N_REQ'(1) << w_pick;
            r_gf_in_0   <= i_op_a[w_pick*SIZE +: SIZE];
            r_gf_in_1   <= i_op_b[w_pick*SIZE +: SIZE];
            r_gf_op_sel <= i_op_sel[w_pick*2 +: 2];
            r_gf_prime  <= i_prime;
          end
        end
        S_WAIT: begin
          // Watchdog abort returns a zero result.
          if (i_gf_done) begin
            r_result <= i_gf_result;
          end else if (w_timeout) begin
            r_result <= '0;
          end
        end
        S_RESP: begin
          r_gnt <= '0;
          r_ptr <= (r_idx == c_PTR_W'(N_REQ - 1)) ? '0 : r_idx + c_PTR_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gf_in_0   = r_gf_in_0;
  assign o_gf_in_1   = r_gf_in_1;
  assign o_gf_prime  = r_gf_prime;
  assign o_gf_op_sel = r_gf_op_sel;

endmodule
`default_nettype wire

// File: tb/tb_gfau_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gfau_arbiter
// Description : Directed self-checking bench for gfau_arbiter with a small
//               behavioural GFAU responder of programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gfau_arbiter;

  localparam int SIZE    = 32;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 16;

  logic                  clk;
  logic                  rst_n;
  logic [N_REQ-1:0]      req;
  logic [N_REQ*SIZE-1:0] op_a;
  logic [N_REQ*SIZE-1:0] op_b;
  logic [N_REQ*2-1:0]    op_sel;
  logic [SIZE-1:0]       prime;
  logic [N_REQ-1:0]      gnt;
  logic [N_REQ-1:0]      ack;
  logic [SIZE-1:0]       result;
  logic                  err;
  logic                  busy;
  logic [SIZE-1:0]       gf_in_0;
  logic [SIZE-1:0]       gf_in_1;
  logic [SIZE-1:0]       gf_prime;
  logic [1:0]            gf_op_sel;
  logic                  gf_start;
  logic [SIZE-1:0]       gf_result;
  logic                  gf_done;
  logic                  model_done;
  logic                  force_done;
  logic                  model_en;
  int                    model_lat;
  int                    model_cnt;

  int n_checks = 0;
  int n_errors = 0;

  assign gf_done = model_done | force_done;

  gfau_arbiter #(
    .SIZE          (SIZE),
    .N_REQ         (N_REQ),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_req      (req),
    .i_op_a     (op_a),
    .i_op_b     (op_b),
    .i_op_sel   (op_sel),
    .i_prime    (prime),
    .o_gnt      (gnt),
    .o_ack      (ack),
    .o_result   (result),
    .o_err      (err),
    .o_busy     (busy),
    .o_gf_in_0  (gf_in_0),
    .o_gf_in_1  (gf_in_1),
    .o_gf_prime (gf_prime),
    .o_gf_op_sel(gf_op_sel),
    .o_gf_start (gf_start),
    .i_gf_result(gf_result),
    .i_gf_done  (gf_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural GFAU: done pulses model_lat cycles after the start cycle.
  function automatic logic [31:0] gf_model(input logic [1:0] sel,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] p);
    logic [63:0] t;
    t = '0;
    if (p != 0) begin
      case (sel)
        2'd0: begin
          t = 64'(a) + 64'(b);
          if (t >= 64'(p)) t = t - 64'(p);
        end
        2'd1: t = (a >= b) ? 64'(a - b) : 64'(a) + 64'(p) - 64'(b);
        2'd2: t = (64'(a) * 64'(b)) % 64'(p);
        default: t = '0;
      endcase
    end
    return t[31:0];
  endfunction

  initial begin
    model_done = 1'b0;
    model_cnt  = 0;
    gf_result  = '0;
    forever begin
      @(posedge clk);
      #1;
      model_done = 1'b0;
      if (model_cnt > 0) begin
        model_cnt = model_cnt - 1;
        if (model_cnt == 0) begin
          model_done = 1'b1;
          gf_result  = gf_model(gf_op_sel, gf_in_0, gf_in_1, gf_prime);
        end
      end
      if (gf_start && model_en) model_cnt = model_lat;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] sel);
    op_a[k*SIZE +: SIZE] = a;
    op_b[k*SIZE +: SIZE] = b;
    op_sel[k*2 +: 2]     = sel;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Returns the number of cycles advanced until an ack is visible.
  task automatic wait_ack(input int budget, output int n);
    n = 0;
    while (ack == '0 && n < budget) begin
      tick();
      n++;
    end
    check("ack_arrived", 64'(ack != '0), 64'd1);
    check("ack_onehot", 64'($countones(ack)), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int seen;
    logic [3:0] exp_ack;

    rst_n      = 1'b0;
    req        = '0;
    op_a       = '0;
    op_b       = '0;
    op_sel     = '0;
    prime      = 32'd97;
    force_done = 1'b0;
    model_en   = 1'b1;
    model_lat  = 3;

    // Reset state
    tick();
    tick();
    check("rst_ctrl", 64'({gnt, ack, err, busy, gf_start, gf_op_sel}), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_gf_ops", {gf_in_0, gf_in_1}, 64'd0);
    check("rst_gf_prime", 64'(gf_prime), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single request: 86 + 53 mod 97 = 42
    set_slot(0, 32'd86, 32'd53, 2'd0);
    req = 4'b0001;
    tick();
    check("single_gnt", 64'(gnt), 64'h1);
    check("single_start", 64'(gf_start), 64'd1);
    check("single_gf_ops", {gf_in_0, gf_in_1}, {32'd86, 32'd53});
    check("single_gf_prime_sel", 64'({gf_prime, gf_op_sel}), 64'({32'd97, 2'd0}));
    wait_ack(20, n);
    check("single_latency", 64'(n), 64'd4);
    check("single_ack", 64'(ack), 64'h1);
    check("single_result", 64'(result), 64'd42);
    check("single_err", 64'(err), 64'd0);
    tick();
    req = '0;
    check("single_after", 64'({result, busy, ack}), 64'd0);
    tick();
    check("single_no_regrant", 64'(busy), 64'd0);

    // Simultaneous requests 1 (sub -> 33) and 2 (mult -> 96)
    do_reset();
    set_slot(1, 32'd86, 32'd53, 2'd1);
    set_slot(2, 32'd86, 32'd53, 2'd2);
    req = 4'b0110;
    tick();
    check("simul_gnt_first", 64'(gnt), 64'h2);
    wait_ack(20, n);
    check("simul_ack1", 64'(ack), 64'h2);
    check("simul_res1", 64'(result), 64'd33);
    tick();
    req = 4'b0100;
    wait_ack(20, n);
    check("simul_ack2", 64'(ack), 64'h4);
    check("simul_res2", 64'(result), 64'd96);
    tick();
    req = '0;
    tick();

    // Fairness: all four held high for eight operations
    do_reset();
    for (int k = 0; k < N_REQ; k++) set_slot(k, 32'(10 + k), 32'd20, 2'd0);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_ack = 4'(1 << (i % 4));
      wait_ack(20, n);
      check("fair_ack", 64'(ack), 64'(exp_ack));
      check("fair_result", 64'(result), 64'(30 + (i % 4)));
      tick();
      if (i == 7) req = '0;
    end
    tick();

    // Reset mid-WAIT: move ptr to 2 first, then abandon requester 3's op
    set_slot(1, 32'd5, 32'd6, 2'd0);
    req = 4'b0010;
    wait_ack(20, n);
    check("pre_rst_result", 64'(result), 64'd11);
    tick();
    req = '0;
    model_en = 1'b0;
    set_slot(3, 32'd7, 32'd8, 2'd0);
    req = 4'b1000;
    tick();
    tick();
    tick();
    check("midwait_busy", 64'({busy, gnt}), 64'({1'b1, 4'b1000}));
    rst_n = 1'b0;
    #1;
    check("async_rst", 64'({busy, gnt, gf_start}), 64'd0);
    tick();
    rst_n = 1'b1;
    req = '0;
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack != '0 || busy) seen++;
    end
    check("stale_done_ignored", 64'(seen), 64'd0);
    model_en = 1'b1;
    set_slot(0, 32'd1, 32'd2, 2'd0);
    req = 4'b1001;
    tick();
    check("ptr_after_reset", 64'(gnt), 64'h1);
    wait_ack(20, n);
    check("post_rst_result", 64'(result), 64'd3);
    tick();
    req = '0;
    tick();

    // Dropped request: requester 3 drops during WAIT, operands disturbed
    model_lat = 4;
    set_slot(3, 32'd40, 32'd50, 2'd2);
    req = 4'b1000;
    tick();
    check("drop_gnt", 64'(gnt), 64'h8);
    tick();
    req = 4'b0101;
    op_a[3*SIZE +: SIZE] = 32'd1;
    set_slot(0, 32'd3, 32'd4, 2'd0);
    set_slot(2, 32'd9, 32'd9, 2'd0);
    wait_ack(20, n);
    check("drop_ack", 64'(ack), 64'h8);
    check("drop_result", 64'(result), 64'd60);
    tick();
    tick();
    check("next_after_drop", 64'(gnt), 64'h1);
    wait_ack(20, n);
    check("next_result", 64'(result), 64'd7);
    tick();
    req = '0;
    tick();

    // Watchdog: GFAU never answers
    model_en = 1'b0;
    set_slot(1, 32'd5, 32'd5, 2'd0);
    req = 4'b0010;
    tick();
    check("to_start", 64'(gf_start), 64'd1);
`ifdef GFAU_ARB_TIMEOUT_EN
    wait_ack(40, n);
    check("to_latency", 64'(n), 64'd17);
    check("to_ack", 64'(ack), 64'h2);
    check("to_err_result", 64'({err, result}), 64'({1'b1, 32'd0}));
    tick();
    req = '0;
    check("to_err_clear", 64'(err), 64'd0);
`else
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ack != '0) seen++;
    end
    check("no_to_ack", 64'(seen), 64'd0);
    check("no_to_busy", 64'(busy), 64'd1);
    req = '0;
    do_reset();
    check("no_to_recover", 64'(busy), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gfau_arbiter.md
# gfau_arbiter

Round-robin arbiter and sequencer that shares one GFAU (GF(p) add/sub/mult/div unit) among `N_REQ` requesters, such as point-add, point-double and inversion engines. It sits between the requesters and the GFAU. It latches one requester's operands, issues a start to the GFAU, waits for the GFAU's done, then returns the result with a one-cycle acknowledge. An optional watchdog aborts operations whose GFAU done never arrives.

## Interface
Parameters:
- `SIZE`, 32, operand/result width (matches GFAU).
- `N_REQ`, 4, number of requesters (2..8).
- `TIMEOUT_CYCLES`, 1024, watchdog limit in cycles. Used only with `GFAU_ARB_TIMEOUT_EN`.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  asynchronous reset, active-low.
- `i_req`  in  N_REQ  per-requester request level.
- `i_op_a`  in  N_REQ*SIZE  packed operand 0; slice k belongs to requester k.
- `i_op_b`  in  N_REQ*SIZE  packed operand 1.
- `i_op_sel`  in  N_REQ*2  packed operation: 0 add, 1 sub, 2 mult, 3 div.
- `i_prime`  in  SIZE  field modulus, shared by all requesters, latched at grant.
- `o_gnt`  out  N_REQ  one-hot: requester currently owning the GFAU.
- `o_ack`  out  N_REQ  one-hot, one-cycle pulse: result valid for that requester.
- `o_result`  out  SIZE  result; valid only while any `o_ack` bit is high.
- `o_err`  out  1  high with `o_ack` when the op was aborted by the watchdog.
- `o_busy`  out  1  high whenever the FSM is not in IDLE.
- `o_gf_in_0`, `o_gf_in_1`, `o_gf_prime`  out  SIZE  registered GFAU operands.
- `o_gf_op_sel`  out  2  registered GFAU operation select.
- `o_gf_start`  out  1  one-cycle start pulse to GFAU (`done_from_control`).
- `i_gf_result`  in  SIZE  GFAU result.
- `i_gf_done`  in  1  GFAU completion pulse (`done_to_control`); `i_gf_result` is valid in the same cycle.

## Operation
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - Round-robin pointer `ptr` = 0.
  - Watchdog counter = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if `i_req` is nonzero, pick the first set bit searching `ptr`, `ptr+1`, … modulo `N_REQ`.
  - Latch that requester's operands, op and `i_prime` into the `o_gf_*` registers.
  - Set `o_gnt`, then go to ISSUE.
  - If `i_req` is 0, stay in IDLE.
- **ISSUE:** assert `o_gf_start` for exactly this cycle, then go to WAIT.
- **WAIT:** on `i_gf_done`, capture `i_gf_result` and go to RESP. Otherwise remain in WAIT.
  - `i_gf_done` in any state other than WAIT is ignored.
- **RESP:**
  - Drive `o_ack[g]` = 1 and `o_result` = captured value.
  - Set `ptr` = (g+1) mod `N_REQ`.
  - Clear `o_gnt`, go to IDLE.
  - `o_result` returns to 0 the next cycle.
- Requester contract:
  - Hold `i_req` and operands stable until its `o_ack`.
  - Drop `i_req` in the cycle after the ack, or keep it high to queue another op.
  - Operands are sampled only at grant, so later changes do not affect an op in flight.
- If `i_req[g]` drops mid-operation, the op still completes and the ack is still pulsed. The arbiter never cancels an op.
- `o_gf_*` operand registers hold their values until the next grant.

## Timing
- Request seen in IDLE at cycle 0:
  - `o_gnt` and `o_gf_*` are valid from cycle 1, with `o_gf_start` high in cycle 1.
  - WAIT begins at cycle 2.
- If `i_gf_done` arrives in cycle d (d ≥ 2), `o_ack` is high in cycle d+1.
- Earliest next grant is cycle d+2. Arbitration overhead is 3 cycles on top of GFAU latency.
- A requester that stays high is re-granted only after every other active requester has been served. This bounds starvation to N_REQ−1 operations.
- Asynchronous reset in any state returns all outputs to their reset values immediately. An in-flight GFAU op is abandoned; its later `i_gf_done` lands in IDLE and is ignored.

## Configuration
- `GFAU_ARB_TIMEOUT_EN` defined:
  - The watchdog counts cycles while in WAIT and clears on leaving WAIT.
  - Reaching `TIMEOUT_CYCLES` without `i_gf_done` forces RESP with `o_result` = 0 and `o_err` = 1.
  - `ptr` advances as normal.
- Not defined: no counter is built, WAIT lasts until `i_gf_done`, and `o_err` is tied to 0.

## Test plan
- Single request: requester 0, op add, a=86, b=53, p=97 → `o_gf_start` one cycle after request; `o_ack`=4'b0001 with `o_result`=42, `o_err`=0.
- Simultaneous requests: `i_req`=4'b0110 after reset, requester 1 sub 86,53 and requester 2 mult 86,53, p=97 → ack order requester 1 (33) then requester 2 (96); never two acks in one cycle.
- Fairness: all four requesters held high for 8 ops → grant order 0,1,2,3,0,1,2,3.
- Reset mid-WAIT: pull `i_rst` low during WAIT, release, then the GFAU pulses done → no ack, `o_busy`=0, next request granted normally from `ptr`=0.
- Dropped request: requester 3 drops `i_req` during WAIT → `o_ack[3]` still pulses with the correct result; the next grant goes to the next requester after 3.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16, GFAU model never signals done) → ack 17 cycles after ISSUE with `o_err`=1 and `o_result`=0. Without the macro, the FSM stays in WAIT indefinitely.
